// File: rtl/synth_pkg.sv
// Shared types and constants for the wavetable voice.
// Interpolation states are only reached when WAVETABLE_LINEAR_INTERP_EN is defined.
package synth_pkg;

  localparam int SAMPLE_BITS       = 16;
  localparam int DEFAULT_FRAC_BITS = 8;

  typedef logic signed [SAMPLE_BITS-1:0] sample_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    FETCH2 = 3'd2,
    INTERP = 3'd3,
    SCALE  = 3'd4,
    OUT    = 3'd5
  } voice_state_e;

endpackage

// File: rtl/sample_table.sv
// Single-cycle wavetable: one synchronous read port, one write port, read-first.
module sample_table
  import synth_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  sample_t              wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output sample_t              rd_data
);

  sample_t mem [DEPTH];

  // No reset on purpose so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule

// File: rtl/wavetable_voice.sv
// DDS wavetable voice: phase accumulator, table lookup, ramped gain, one sample per request.
// Define WAVETABLE_LINEAR_INTERP_EN to interpolate between adjacent entries (adds two cycles).
module wavetable_voice
  import synth_pkg::*;
#(
  parameter int CLIP_LEN    = 256,
  parameter int PHASE_BITS  = 24,
  parameter int VOLUME_BITS = 8,
  parameter int ADDR_BITS   = $clog2(CLIP_LEN),
  parameter int FRAC_BITS   = DEFAULT_FRAC_BITS
) (
  input  logic                   mclk,
  input  logic                   rst,
  input  logic                   tbl_wr_en,
  input  logic [ADDR_BITS-1:0]   tbl_wr_addr,
  input  sample_t                tbl_wr_data,
  input  logic                   enable,
  input  logic [PHASE_BITS-1:0]  phase_inc,
  input  logic [VOLUME_BITS-1:0] volume_target,
  input  logic                   sample_req,
  output sample_t                sample_out,
  output logic                   sample_valid,
  output logic                   busy,
  output logic                   overrun,
  output logic [ADDR_BITS-1:0]   phase_index,
  output voice_state_e           state_dbg
);

  localparam int MULT_W = SAMPLE_BITS + VOLUME_BITS + 1;

  // Handshake: a request is the rising edge of sample_req; sample_valid pulses for
  // exactly one cycle with sample_out; busy covers every cycle after the accept
  // up to and including the valid cycle.
  voice_state_e            state, state_nxt;
  logic                    req_d;
  logic                    accept;
  logic [PHASE_BITS-1:0]   acc;
  logic [VOLUME_BITS-1:0]  vol_cur;
  logic [ADDR_BITS-1:0]    idx;
  logic [ADDR_BITS-1:0]    rd_addr;
  sample_t                 rd_data;
  sample_t                 s_sel;
  logic signed [MULT_W-1:0] mult;
  sample_t                 scaled;

  assign accept       = sample_req & ~req_d;
  assign idx          = acc[PHASE_BITS-1 -: ADDR_BITS];
  assign busy         = (state != IDLE);
  assign sample_valid = (state == OUT);
  assign phase_index  = idx;
  assign state_dbg    = state;

`ifdef WAVETABLE_LINEAR_INTERP_EN
  localparam int DIFF_W = SAMPLE_BITS + 1;
  localparam int PROD_W = DIFF_W + FRAC_BITS + 1;

  logic [FRAC_BITS-1:0]     frac;
  sample_t                  s0;
  sample_t                  s_reg;
  sample_t                  s_interp;
  logic signed [DIFF_W-1:0] diff;
  logic signed [PROD_W-1:0] prod;

  assign frac    = acc[PHASE_BITS-ADDR_BITS-1 -: FRAC_BITS];
  assign rd_addr = (state == FETCH2) ? idx + ADDR_BITS'(1) : idx;

  // frac < 2^FRAC_BITS, so the floored step never overshoots s1.
  always_comb begin
    diff     = DIFF_W'(rd_data) - DIFF_W'(s0);
    prod     = PROD_W'(diff) * PROD_W'($signed({1'b0, frac}));
    s_interp = sample_t'(DIFF_W'(s0) + DIFF_W'(prod >>> FRAC_BITS));
  end

  always_ff @(posedge mclk) begin
    if (state == FETCH2) s0 <= rd_data;
    if (state == INTERP) s_reg <= s_interp;
  end

  assign s_sel = s_reg;
`else
  assign rd_addr = idx;
  assign s_sel   = rd_data;
`endif

  sample_table #(
    .DEPTH     (CLIP_LEN),
    .ADDR_BITS (ADDR_BITS)
  ) u_table (
    .clk     (mclk),
    .wr_en   (tbl_wr_en),
    .wr_addr (tbl_wr_addr),
    .wr_data (tbl_wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Gain is unsigned; the extra zero bit keeps the product signed.
  always_comb begin
    mult   = MULT_W'(s_sel) * MULT_W'($signed({1'b0, vol_cur}));
    scaled = sample_t'(mult >>> VOLUME_BITS);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (accept) state_nxt = FETCH;
`ifdef WAVETABLE_LINEAR_INTERP_EN
      FETCH:  state_nxt = FETCH2;
`else
      FETCH:  state_nxt = SCALE;
`endif
      FETCH2: state_nxt = INTERP;
      INTERP: state_nxt = SCALE;
      SCALE:  state_nxt = OUT;
      OUT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      state      <= IDLE;
      req_d      <= 1'b0;
      acc        <= '0;
      vol_cur    <= '0;
      sample_out <= '0;
      overrun    <= 1'b0;
    end else begin
      state <= state_nxt;
      req_d <= sample_req;
      if (accept && state != IDLE) overrun <= 1'b1;
      if (state == SCALE) sample_out <= enable ? scaled : '0;
      if (state == OUT) begin
        if (enable) acc <= acc + phase_inc;
        if (vol_cur < volume_target)      vol_cur <= vol_cur + VOLUME_BITS'(1);
        else if (vol_cur > volume_target) vol_cur <= vol_cur - VOLUME_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_wavetable_voice.sv
// Self-checking bench for wavetable_voice against an arithmetic model of the voice.
// Expectations follow WAVETABLE_LINEAR_INTERP_EN when it is defined for the build.
module tb_wavetable_voice;
  import synth_pkg::*;

  localparam int CLIP = 256;
`ifdef WAVETABLE_LINEAR_INTERP_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic         mclk = 1'b0;
  logic         rst = 1'b1;
  logic         tbl_wr_en = 1'b0;
  logic [7:0]   tbl_wr_addr = '0;
  sample_t      tbl_wr_data = '0;
  logic         enable = 1'b1;
  logic [23:0]  phase_inc = '0;
  logic [7:0]   volume_target = '0;
  logic         sample_req = 1'b0;
  sample_t      sample_out;
  logic         sample_valid;
  logic         busy;
  logic         overrun;
  logic [7:0]   phase_index;
  voice_state_e state_dbg;

  wavetable_voice dut (
    .mclk          (mclk),
    .rst           (rst),
    .tbl_wr_en     (tbl_wr_en),
    .tbl_wr_addr   (tbl_wr_addr),
    .tbl_wr_data   (tbl_wr_data),
    .enable        (enable),
    .phase_inc     (phase_inc),
    .volume_target (volume_target),
    .sample_req    (sample_req),
    .sample_out    (sample_out),
    .sample_valid  (sample_valid),
    .busy          (busy),
    .overrun       (overrun),
    .phase_index   (phase_index),
    .state_dbg     (state_dbg)
  );

  // clock / cycle counter
  always #5 mclk = ~mclk;
  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  // model state
  int m_tbl [CLIP];
  int m_acc = 0;
  int m_vol = 0;
  int last_acc = -1000;
  int idx_exp = 0;
  bit ov_exp = 1'b0;
  bit chk_en = 1'b0;
  logic [15:0] exp_q[$];
  int due_q[$];
  int nidx_q[$];
  int out_log[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // compare process: every cycle while checking is enabled
  always @(negedge mclk) begin
    if (chk_en) begin
      bit due;
      bit busy_exp;
      due = (due_q.size() > 0) && (due_q[0] == cyc);
      busy_exp = (cyc > last_acc) && (cyc <= last_acc + LAT);
      chk("sample_valid", int'(sample_valid), int'(due));
      chk("busy", int'(busy), int'(busy_exp));
      chk("overrun", int'(overrun), int'(ov_exp));
      chk("phase_index", int'(phase_index), idx_exp);
      if (due) begin
        chk("sample_out", int'(sample_out), int'($signed(exp_q[0])));
        out_log.push_back(int'(sample_out));
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
        idx_exp = nidx_q.pop_front();
      end
    end
  end

  // driver tasks: all called just after a rising edge
  task automatic wr(input int addr, input int data);
    tbl_wr_en   = 1'b1;
    tbl_wr_addr = addr[7:0];
    tbl_wr_data = data[15:0];
    m_tbl[addr] = data;
    @(posedge mclk); #1;
    tbl_wr_en = 1'b0;
  endtask

  task automatic issue();
    int idx, frac, s, o;
    idx  = m_acc >> 16;
    frac = (m_acc >> 8) & 255;
    s    = m_tbl[idx];
`ifdef WAVETABLE_LINEAR_INTERP_EN
    s = s + (((m_tbl[(idx + 1) % CLIP] - s) * frac) >>> 8);
`endif
    o = enable ? ((s * m_vol) >>> 8) : 0;
    if (enable) m_acc = (m_acc + int'(phase_inc)) & 32'h00FF_FFFF;
    if (m_vol < int'(volume_target)) m_vol++;
    else if (m_vol > int'(volume_target)) m_vol--;
    exp_q.push_back(o[15:0]);
    due_q.push_back(cyc + LAT);
    nidx_q.push_back(m_acc >> 16);
    last_acc   = cyc;
    sample_req = 1'b1;
  endtask

  task automatic do_req(input int gap);
    issue();
    @(posedge mclk); #1;
    sample_req = 1'b0;
    repeat (LAT + gap) begin
      @(posedge mclk); #1;
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_vol = 0; idx_exp = 0; ov_exp = 1'b0; last_acc = -1000;
    exp_q.delete(); due_q.delete(); nidx_q.delete();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: bench did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, ridx, a;
    repeat (3) begin @(posedge mclk); #1; end
    chk("rst_sample_out", int'(sample_out), 0);
    chk("rst_valid", int'(sample_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_phase_index", int'(phase_index), 0);
    rst = 1'b0;
    @(posedge mclk); #1;
    chk_en = 1'b1;

    // ramp: table[i] = i*64, target 255, one index per request
    for (int i = 0; i < CLIP; i++) wr(i, i * 64);
    volume_target = 8'd255;
    phase_inc = 24'h010000;
    out_log.delete();
    for (int k = 0; k < 300; k++) do_req(k % 2);
    chk("ramp_s0", out_log[0], 0);
    chk("ramp_s2", out_log[2], 1);
    chk("ramp_s255", out_log[255], 16256);
    chk("ramp_s256", out_log[256], 0);
    chk("ramp_s299", out_log[299], 2741);
    chk("ramp_idx", int'(phase_index), 44);

    // half-step tuning from index 44
    wr(44, 0);
    wr(45, 1000);
    phase_inc = 24'h008000;
    base = out_log.size();
    for (int k = 0; k < 4; k++) do_req(0);
    chk("half_s0", out_log[base], 0);
`ifdef WAVETABLE_LINEAR_INTERP_EN
    chk("half_s1", out_log[base + 1], 498);
`else
    chk("half_s1", out_log[base + 1], 0);
`endif
    chk("half_s2", out_log[base + 2], 996);

    // move to index 255, frac 0xFF and read across the table wrap
    wr(255, -32768);
    wr(0, 32767);
    phase_inc = 24'hD1FF00;
    do_req(0);
    phase_inc = 24'h000100;
    base = out_log.size();
    do_req(0);
`ifdef WAVETABLE_LINEAR_INTERP_EN
    chk("wrap_interp", out_log[base], 32384);
`else
    chk("wrap_nearest", out_log[base], -32640);
`endif
    chk("wrap_idx", int'(phase_index), 0);

    // second rising edge two cycles after accept: dropped, overrun sticks
    phase_inc = 24'h030000;
    issue();
    @(posedge mclk); #1; sample_req = 1'b0;
    @(posedge mclk); #1; sample_req = 1'b1;
    @(posedge mclk); #1; sample_req = 1'b0; ov_exp = 1'b1;
    repeat (LAT) begin @(posedge mclk); #1; end

    // enable low: outputs zero, phase frozen, gain still ramps
    volume_target = 8'd200;
    enable = 1'b0;
    for (int k = 0; k < 4; k++) do_req(1);
    enable = 1'b1;
    do_req(0);

    // write the entry being fetched during its FETCH cycle: old data wins
    ridx = m_acc >> 16;
    issue();
    @(posedge mclk); #1;
    sample_req = 1'b0;
    wr(ridx, 12345);
    repeat (LAT - 1) begin @(posedge mclk); #1; end

    // randomized traffic
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 1) == 1) wr($urandom_range(0, CLIP - 1), int'($urandom_range(0, 65535)) - 32768);
      phase_inc = 24'($urandom_range(0, 24'hFFFFFF));
      if ($urandom_range(0, 3) == 0) volume_target = 8'($urandom_range(0, 255));
      enable = ($urandom_range(0, 3) != 0);
      do_req($urandom_range(0, 2));
    end
    enable = 1'b1;

    // reset while the request is in its SCALE cycle
    issue();
    a = cyc;
    @(posedge mclk); #1;
    sample_req = 1'b0;
    while (cyc < a + LAT - 1) begin @(posedge mclk); #1; end
    rst = 1'b1;
    chk_en = 1'b0;
    model_reset();
    @(posedge mclk); #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(sample_valid), 0);
    chk("abort_sample_out", int'(sample_out), 0);
    chk("abort_overrun", int'(overrun), 0);
    chk("abort_phase_index", int'(phase_index), 0);
    rst = 1'b0;
    @(posedge mclk); #1;
    chk("abort_no_late_valid", int'(sample_valid), 0);
    chk_en = 1'b1;
    volume_target = 8'd255;
    phase_inc = 24'h050000;
    do_req(0);
    do_req(0);
    chk("post_rst_idx", int'(phase_index), 10);

    chk("queue_drained", due_q.size(), 0);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
